// File: rtl/adder_exhaustive_checker.sv
// adder_exhaustive_checker: walks all 16 two-bit operand pairs into an adder and checks {c,s1,s0}; ports clk, rst, start, c/s1/s0 in; a1/a0/b1/b0, busy, sample_strobe, done, pass, err_count, first_fail_code, first_fail_valid out
module adder_exhaustive_checker #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       c,
   input  logic       s1,
   input  logic       s0,
   output logic       a1,
   output logic       a0,
   output logic       b1,
   output logic       b0,
   output logic       busy,
   output logic       sample_strobe,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic [3:0] first_fail_code,
   output logic       first_fail_valid
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
   localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
   state_t state;
   logic [3:0] code;
   logic [3:0] cnt;
   logic mismatch;
   assign {a1, a0, b1, b0} = code;
   assign mismatch = ({1'b0, code[3:2]} + {1'b0, code[1:0]}) != {c, s1, s0};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= ST_IDLE;
         code <= '0;
         cnt <= '0;
         err_count <= '0;
         first_fail_code <= '0;
         first_fail_valid <= 1'b0;
         busy <= 1'b0;
         sample_strobe <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
      end else
         case (state)
            ST_IDLE, ST_DONE:
               if (start) begin
                  state <= ST_SETTLE;
                  code <= '0;
                  cnt <= RELOAD;
                  err_count <= '0;
                  first_fail_code <= '0;
                  first_fail_valid <= 1'b0;
                  busy <= 1'b1;
                  done <= 1'b0;
                  pass <= 1'b0;
               end
            ST_SETTLE:
               if (cnt == 4'd0) begin
                  state <= ST_SAMPLE;
                  sample_strobe <= 1'b1;
               end else
                  cnt <= cnt - 4'd1;
            ST_SAMPLE: begin
               sample_strobe <= 1'b0;
               if (mismatch) begin
                  err_count <= err_count + 5'd1;
                  if (!first_fail_valid) begin
                     first_fail_code <= code;
                     first_fail_valid <= 1'b1;
                  end
               end
               if (code == 4'd15) begin
                  state <= ST_DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (err_count == 5'd0) && !mismatch;
               end else begin
                  state <= ST_SETTLE;
                  code <= code + 4'd1;
                  cnt <= RELOAD;
               end
            end
            default: state <= ST_IDLE;
         endcase
endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// tb_adder_exhaustive_checker: scoreboard bench for the checker with SETTLE=1 and SETTLE=3 instances and a faultable adder model
module tb_adder_exhaustive_checker;
   typedef struct {int code; int cyc;} exp_t;
   typedef struct {int cyc; int errs; int ff; int ffv;} verd_t;
   logic clk = 1'b0;
   logic rst;
   logic [1:0] start, c, s1, s0, a1, a0, b1, b0, busy, strobe, done, pass, ffv;
   logic [4:0] errc [2];
   logic [3:0] ffc [2];
   int fault [2];
   logic [2:0] mask [2][16];
   int clr [2];
   int cyc = 0;
   int errors = 0;
   int checks = 0;
   exp_t cq [2][$];
   verd_t vq [2][$];
   logic [1:0] pd = '0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   for (genvar g = 0; g < 2; g++) begin : u
      adder_exhaustive_checker #(.SETTLE(g == 0 ? 1 : 3)) dut (
         .clk(clk), .rst(rst), .start(start[g]), .c(c[g]), .s1(s1[g]), .s0(s0[g]),
         .a1(a1[g]), .a0(a0[g]), .b1(b1[g]), .b0(b0[g]), .busy(busy[g]),
         .sample_strobe(strobe[g]), .done(done[g]), .pass(pass[g]),
         .err_count(errc[g]), .first_fail_code(ffc[g]), .first_fail_valid(ffv[g])
      );
   end
   function automatic logic [2:0] faulty(input int f, input logic [2:0] m, input int k);
      logic [2:0] s;
      s = 3'(k / 4 + k % 4);
      return f == 1 ? (s & 3'b110) : f == 2 ? (s ^ 3'b100) : f == 3 ? (s ^ m) : s;
   endfunction
   always_comb
      for (int g = 0; g < 2; g++)
         {c[g], s1[g], s0[g]} = faulty(fault[g], mask[g][{a1[g], a0[g], b1[g], b0[g]}],
                                       int'({a1[g], a0[g], b1[g], b0[g]}));
   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      verd_t v;
      for (int g = 0; g < 2; g++) begin
         if (rst)
            chk("reset_outputs", int'({a1[g], a0[g], b1[g], b0[g], busy[g], strobe[g], done[g],
                                       pass[g], errc[g], ffc[g], ffv[g]}), 0);
         else begin
            if (cq[g].size() > 0) begin
               if (strobe[g]) begin
                  e = cq[g].pop_front();
                  chk("strobe_cycle", cyc, e.cyc);
                  chk("strobe_code", int'({a1[g], a0[g], b1[g], b0[g]}), e.code);
                  chk("busy_in_sample", int'(busy[g]), 1);
                  chk("pass_while_busy", int'(pass[g]), 0);
               end else if (cyc > cq[g][0].cyc) begin
                  e = cq[g].pop_front();
                  chk("strobe_missing", int'(strobe[g]), 1);
               end
            end else if (strobe[g])
               chk("unexpected_strobe", int'(strobe[g]), 0);
            if (cyc == clr[g]) begin
               chk("clear_err_count", int'(errc[g]), 0);
               chk("clear_first_fail_valid", int'(ffv[g]), 0);
               chk("clear_done", int'(done[g]), 0);
            end
            if (vq[g].size() > 0 && cyc >= vq[g][0].cyc) begin
               v = vq[g].pop_front();
               chk("done_rise", int'({pd[g], done[g]}), 1);
               chk("err_count", int'(errc[g]), v.errs);
               chk("pass", int'(pass[g]), v.errs == 0 ? 1 : 0);
               chk("first_fail_valid", int'(ffv[g]), v.ffv);
               if (v.ffv != 0) chk("first_fail_code", int'(ffc[g]), v.ff);
               chk("busy_in_done", int'(busy[g]), 0);
               chk("code_in_done", int'({a1[g], a0[g], b1[g], b0[g]}), 15);
            end
         end
         pd[g] = done[g];
      end
   end
   task automatic run(input int g, input int f, input int rst_at);
      int s, base, errs, ff;
      verd_t v;
      s = g == 0 ? 1 : 3;
      fault[g] = f;
      if (f == 3)
         for (int k = 0; k < 16; k++) mask[g][k] = 3'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk) start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
      base = cyc - 1;
      clr[g] = base + 1;
      errs = 0;
      ff = -1;
      for (int k = 0; k < 16; k++) begin
         cq[g].push_back('{code: k, cyc: base + 1 + k * (s + 1) + s});
         if (int'(faulty(f, mask[g][k], k)) != k / 4 + k % 4) begin
            errs++;
            if (ff < 0) ff = k;
         end
      end
      v = '{cyc: base + 16 * (s + 1) + 1, errs: errs, ff: ff, ffv: ff >= 0 ? 1 : 0};
      if (rst_at == 0) vq[g].push_back(v);
      if (g == 1 && f == 0) begin
         while (cyc < base + 10) @(negedge clk);
         start[g] = 1'b1;
         @(negedge clk) start[g] = 1'b0;
         while (cyc < base + 40) @(negedge clk);
         start[g] = 1'b1;
         @(negedge clk) start[g] = 1'b0;
      end
      if (rst_at > 0) begin
         do begin
            @(posedge clk);
            #1;
         end while (cyc < base + rst_at);
         rst = 1'b1;
         for (int i = 0; i < 2; i++) begin
            cq[i].delete();
            vq[i].delete();
            clr[i] = -1;
         end
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         return;
      end
      for (int i = 0; i < 200 && vq[g].size() > 0; i++) @(negedge clk);
      @(negedge clk);
   endtask
   initial begin
      rst = 1'b1;
      start = '0;
      fault = '{0, 0};
      clr = '{-1, -1};
      for (int g = 0; g < 2; g++)
         for (int k = 0; k < 16; k++) mask[g][k] = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      run(0, 0, 0);
      run(0, 1, 0);
      run(0, 0, 0);
      run(0, 2, 0);
      run(1, 0, 0);
      run(0, 3, 0);
      run(0, 3, 0);
      run(0, 1, 12);
      run(0, 0, 0);
      run(1, 3, 0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
